subsys_lifecycle_seq: RTL and testbench
=======================================

# subsys_lifecycle_seq

Hardware bring-up/tear-down sequencer for the engine's subsystem stack (boot/WM, system, assets, GFX, audio, scripts, input). It sits directly upstream of the API aggregate. It drives per-subsystem init and shutdown request/acknowledge handshakes in a fixed order and tracks which subsystems are alive. It publishes a single `healthy_o` flag that the API health check consumes. It also handles init failure by unwinding already-initialised subsystems in reverse order.

## Interface
- `N_SUB`, default 8: number of subsystems; index 0 is initialised first.
- `TMO_W`, default 16: width of the watchdog counter.
- `TMO_CYC`, default 1000: cycles allowed per handshake before timeout. Must be less than 2^TMO_W.
- `IDX_W`, default `$clog2(N_SUB)`: width of the index fields.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_i`  in  1  single-cycle request to bring the stack up.
- `stop_i`  in  1  single-cycle request to tear the stack down.
- `init_req_o`  out  N_SUB  one-hot init request, held until acknowledged.
- `init_ack_i`  in  N_SUB  init success; only the bit matching `init_req_o` is sampled.
- `init_err_i`  in  N_SUB  init failure; same sampling rule as `init_ack_i`. Error wins over ack.
- `shut_req_o`  out  N_SUB  one-hot shutdown request, held until acknowledged.
- `shut_ack_i`  in  N_SUB  shutdown complete.
- `alive_o`  out  N_SUB  per-subsystem initialised flag.
- `state_o`  out  3  current state code.
- `busy_o`  out  1  high in INIT, SHUT and UNWIND.
- `healthy_o`  out  1  high when state is READY and `alive_o` is all-ones.
- `fault_o`  out  1  sticky fault flag.
- `fault_idx_o`  out  IDX_W  index of the first subsystem that faulted.
- `fault_tmo_o`  out  1  first fault was a timeout, not an error.

## Operation
State codes: IDLE=0, INIT=1, READY=2, SHUT=3, UNWIND=4, FAULT=5.

Transitions:
- **IDLE** + `start_i` → INIT with idx=0, fault fields cleared. `stop_i` is ignored in IDLE.
- **INIT**: assert `init_req_o[idx]`.
  - On ack: set `alive_o[idx]`. If idx=N_SUB-1 → READY, otherwise idx+1.
  - On error or timeout: latch the fault. If idx=0 → FAULT, otherwise → UNWIND with idx-1.
- **READY**: `stop_i` → SHUT with idx=N_SUB-1. `start_i` is ignored.
- **SHUT**: assert `shut_req_o[idx]`.
  - On ack or timeout: clear `alive_o[idx]`. A timeout also latches a fault if none is latched yet; shutdown always continues.
  - At idx=0: → IDLE if no fault, otherwise → FAULT.
- **UNWIND**: same as SHUT but starts from the failed index minus 1, and always ends in FAULT.
- **FAULT**: `start_i` → INIT with idx=0 and fault fields cleared. `stop_i` is ignored.

Rules:
- `stop_i` during INIT is latched as a pending stop. The current handshake completes, then the block enters SHUT from the highest alive index instead of advancing. If the handshake ends in error, UNWIND takes precedence and the pending stop is dropped.
- `start_i` during SHUT or UNWIND is ignored (not queued).
- Only the first fault is recorded in `fault_idx_o` / `fault_tmo_o`; `fault_o` stays high until the next accepted `start_i`.
- Request outputs are registered and at most one bit is set across `init_req_o | shut_req_o`.
- Ack/err bits other than the active index are ignored.

## Timing
- Reset values: all request outputs 0, `alive_o`=0, `state_o`=IDLE, `busy_o`=0, `healthy_o`=0, `fault_o`=0, `fault_idx_o`=0, `fault_tmo_o`=0, watchdog=0.
- `start_i` sampled at edge k → `init_req_o[0]` high from k+1.
- Ack sampled at edge m → the current request drops at m+1 and the next request rises at m+1 (no gap).
- An ack presented in the first cycle its request is high is accepted. The minimum full init is therefore N_SUB cycles after the request, and READY/`healthy_o` is asserted at the edge after the last ack.
- Watchdog:
  - Cleared on every request change.
  - Increments each cycle a request is held.
  - Timeout fires on the edge where count = TMO_CYC-1 without ack/err, i.e. the request was high for TMO_CYC cycles.
- Asynchronous reset mid-handshake drops all requests immediately and clears `alive_o`. No shutdown handshake is issued.

## Configuration
- `SUBSYS_SEQ_TIMEOUT_EN` defined: watchdog counter and `fault_tmo_o` behave as above.
- Undefined: no counter is synthesised, handshakes wait indefinitely, and `fault_tmo_o` is tied to 0.

## Test plan
- N_SUB=8, `start_i`, every ack in the first request cycle → `init_req_o` walks 0x01..0x80 over 8 cycles; `healthy_o`=1 and `alive_o`=0xFF at cycle 9.
- READY, `stop_i` → `shut_req_o` walks 0x80..0x01; `alive_o` clears high bit first; IDLE with `fault_o`=0.
- `init_err_i[3]` when idx=3 → UNWIND shuts down 2,1,0; FAULT with `fault_idx_o`=3, `fault_tmo_o`=0, `alive_o`=0.
- Timeout build, TMO_CYC=10, no ack on idx 5 → fault after 10 request cycles; `fault_tmo_o`=1, then unwind 4..0.
- `stop_i` while idx=2 is waiting, then ack → SHUT from idx 2 down to 0; ends in IDLE.
- `rst_n` low during idx 4 handshake → all outputs at reset values immediately; a subsequent `start_i` restarts at idx 0.

Source files
------------

// File: rtl/subsys_lifecycle_seq.sv
// subsys_lifecycle_seq: ordered init/shutdown sequencer for the subsystem stack
// with reverse-order unwind on init failure, a sticky first-fault record and a
// single health flag.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start_i        bring-up request (pulse); stop_i tear-down request (pulse)
//   init_req_o     one-hot init request; init_ack_i / init_err_i responses
//   shut_req_o     one-hot shutdown request; shut_ack_i response
//   alive_o        per-subsystem initialised flags
//   state_o        IDLE=0 INIT=1 READY=2 SHUT=3 UNWIND=4 FAULT=5
//   busy_o         high in INIT, SHUT, UNWIND
//   healthy_o      READY with every subsystem alive
//   fault_o        sticky fault; fault_idx_o / fault_tmo_o describe the first
//
// Build option: define SUBSYS_SEQ_TIMEOUT_EN to add the per-handshake watchdog.
// Without it, handshakes wait forever and fault_tmo_o is tied low.
module subsys_lifecycle_seq #(
  parameter int N_SUB   = 8,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 1000,
  parameter int IDX_W   = $clog2(N_SUB)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [N_SUB-1:0] init_req_o,
  input  logic [N_SUB-1:0] init_ack_i,
  input  logic [N_SUB-1:0] init_err_i,
  output logic [N_SUB-1:0] shut_req_o,
  input  logic [N_SUB-1:0] shut_ack_i,
  output logic [N_SUB-1:0] alive_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             healthy_o,
  output logic             fault_o,
  output logic [IDX_W-1:0] fault_idx_o,
  output logic             fault_tmo_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_READY  = 3'd2,
    S_SHUT   = 3'd3,
    S_UNWIND = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SUB - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [N_SUB-1:0] r_alive;
  logic [N_SUB-1:0] r_init_req;
  logic [N_SUB-1:0] r_shut_req;
  logic             r_stop_pend;
  logic             r_fault;
  logic [IDX_W-1:0] r_fault_idx;
  logic             r_fault_tmo;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N_SUB-1:0] w_alive_nxt;
  logic [N_SUB-1:0] w_ireq_nxt;
  logic [N_SUB-1:0] w_sreq_nxt;
  logic [N_SUB-1:0] w_onehot;
  logic             w_stop_nxt;
  logic             w_fault_nxt;
  logic [IDX_W-1:0] w_fidx_nxt;
  logic             w_ftmo_nxt;
  logic             w_iack;
  logic             w_ierr;
  logic             w_sack;
  logic             w_tmo;
  logic             w_req_on;
  logic             w_req_chg;

  // Only the response bit lined up with the live request is observed.
  assign w_iack   = |(init_ack_i & r_init_req);
  assign w_ierr   = |(init_err_i & r_init_req);
  assign w_sack   = |(shut_ack_i & r_shut_req);
  assign w_req_on = |(r_init_req | r_shut_req);
  assign w_req_chg = (w_ireq_nxt != r_init_req) ||
                     (w_sreq_nxt != r_shut_req);

`ifdef SUBSYS_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_req_chg) begin
      r_wdog <= '0;
    end else if (w_req_on) begin
      r_wdog <= r_wdog + TMO_W'(1);
    end
  end

  // Fires in the TMO_CYC-th cycle of a held request.
  assign w_tmo = w_req_on &&
                 (r_wdog == TMO_W'(TMO_CYC - 1));
  assign fault_tmo_o = r_fault_tmo;
`else
  logic w_unused;
  assign w_unused = ^{TMO_W, TMO_CYC, w_req_chg,
                      w_req_on, r_fault_tmo};
  assign w_tmo       = 1'b0;
  assign fault_tmo_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_alive_nxt = r_alive;
    w_stop_nxt  = r_stop_pend;
    w_fault_nxt = r_fault;
    w_fidx_nxt  = r_fault_idx;
    w_ftmo_nxt  = r_fault_tmo;
    unique case (r_state)
      S_IDLE, S_FAULT: begin
        if (start_i) begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_fault_nxt = 1'b0;
          w_fidx_nxt  = '0;
          w_ftmo_nxt  = 1'b0;
        end
      end
      S_INIT: begin
        if (stop_i) w_stop_nxt = 1'b1;
        if (w_ierr || (w_tmo && !w_iack)) begin
          // Error beats ack; a pending stop is dropped.
          w_stop_nxt = 1'b0;
          if (!r_fault) begin
            w_fault_nxt = 1'b1;
            w_fidx_nxt  = r_idx;
            w_ftmo_nxt  = !w_ierr;
          end
          if (r_idx == '0) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_UNWIND;
            w_idx_nxt   = r_idx - IDX_W'(1);
          end
        end else if (w_iack) begin
          w_alive_nxt[r_idx] = 1'b1;
          if (r_stop_pend || stop_i) begin
            // r_idx is now the highest alive subsystem.
            w_stop_nxt  = 1'b0;
            w_state_nxt = S_SHUT;
          end else if (r_idx == LAST) begin
            w_state_nxt = S_READY;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_READY: begin
        if (stop_i) begin
          w_state_nxt = S_SHUT;
          w_idx_nxt   = LAST;
        end
      end
      S_SHUT, S_UNWIND: begin
        if (w_sack || w_tmo) begin
          w_alive_nxt[r_idx] = 1'b0;
          if (!w_sack && !r_fault) begin
            w_fault_nxt = 1'b1;
            w_fidx_nxt  = r_idx;
            w_ftmo_nxt  = 1'b1;
          end
          if (r_idx == '0) begin
            if (r_state == S_UNWIND || w_fault_nxt) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_onehot = N_SUB'(1) << w_idx_nxt;

  always_comb begin
    w_ireq_nxt = '0;
    w_sreq_nxt = '0;
    if (w_state_nxt == S_INIT) begin
      w_ireq_nxt = w_onehot;
    end
    if (w_state_nxt == S_SHUT ||
        w_state_nxt == S_UNWIND) begin
      w_sreq_nxt = w_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_alive     <= '0;
      r_init_req  <= '0;
      r_shut_req  <= '0;
      r_stop_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_fault_idx <= '0;
      r_fault_tmo <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_alive     <= w_alive_nxt;
      r_init_req  <= w_ireq_nxt;
      r_shut_req  <= w_sreq_nxt;
      r_stop_pend <= w_stop_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_idx <= w_fidx_nxt;
      r_fault_tmo <= w_ftmo_nxt;
    end
  end

  assign init_req_o  = r_init_req;
  assign shut_req_o  = r_shut_req;
  assign alive_o     = r_alive;
  assign state_o     = r_state;
  assign busy_o      = (r_state == S_INIT) ||
                       (r_state == S_SHUT) ||
                       (r_state == S_UNWIND);
  assign healthy_o   = (r_state == S_READY) && (&r_alive);
  assign fault_o     = r_fault;
  assign fault_idx_o = r_fault_idx;

endmodule

// File: tb/tb_subsys_lifecycle_seq.sv
// tb_subsys_lifecycle_seq: directed bench for subsys_lifecycle_seq.
// Inputs change on negedge, outputs checked on negedge.
module tb_subsys_lifecycle_seq;

  localparam int N = 8;
  localparam int W = 3;
`ifdef SUBSYS_SEQ_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, stop_i;
  logic [N-1:0] init_req_o, init_ack_i, init_err_i;
  logic [N-1:0] shut_req_o, shut_ack_i, alive_o;
  logic [2:0]   state_o;
  logic         busy_o, healthy_o, fault_o, fault_tmo_o;
  logic [W-1:0] fault_idx_o;

  int n_cmp = 0;
  int n_bad = 0;

  subsys_lifecycle_seq #(
    .N_SUB(N), .TMO_W(16), .TMO_CYC(10), .IDX_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .stop_i(stop_i),
    .init_req_o(init_req_o), .init_ack_i(init_ack_i),
    .init_err_i(init_err_i),
    .shut_req_o(shut_req_o), .shut_ack_i(shut_ack_i),
    .alive_o(alive_o), .state_o(state_o),
    .busy_o(busy_o), .healthy_o(healthy_o),
    .fault_o(fault_o), .fault_idx_o(fault_idx_o),
    .fault_tmo_o(fault_tmo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ireq"},  32'(init_req_o), 0);
    chk({tag, "_sreq"},  32'(shut_req_o), 0);
    chk({tag, "_alive"}, 32'(alive_o), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_hlth"},  32'(healthy_o), 0);
    chk({tag, "_flt"},   32'(fault_o), 0);
    chk({tag, "_fidx"},  32'(fault_idx_o), 0);
    chk({tag, "_ftmo"},  32'(fault_tmo_o), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 0; stop_i = 0;
    init_ack_i = 0; init_err_i = 0; shut_ack_i = 0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full bring-up, ack in first request cycle.
    pulse_start();
    chk("up_req0", 32'(init_req_o), 32'h01);
    chk("up_st", 32'(state_o), 1);
    chk("up_busy", 32'(busy_o), 1);
    chk("up_hlth0", 32'(healthy_o), 0);
    init_ack_i = 8'hFF;
    for (int i = 1; i < N; i++) begin
      step();
      chk($sformatf("up_req%0d", i),
          32'(init_req_o), 32'(1 << i));
      chk($sformatf("up_alv%0d", i),
          32'(alive_o), 32'((1 << i) - 1));
    end
    step();
    init_ack_i = 0;
    chk("rdy_st", 32'(state_o), 2);
    chk("rdy_ireq", 32'(init_req_o), 0);
    chk("rdy_alive", 32'(alive_o), 32'hFF);
    chk("rdy_hlth", 32'(healthy_o), 1);
    chk("rdy_busy", 32'(busy_o), 0);
    pulse_start();
    chk("rdy_start_ign", 32'(state_o), 2);

    // Orderly shutdown.
    pulse_stop();
    chk("sh_st", 32'(state_o), 3);
    chk("sh_req7", 32'(shut_req_o), 32'h80);
    chk("sh_hlth", 32'(healthy_o), 0);
    shut_ack_i = 8'hFF;
    for (int i = N - 2; i >= 0; i--) begin
      step();
      chk($sformatf("sh_req%0d", i),
          32'(shut_req_o), 32'(1 << i));
      chk($sformatf("sh_alv%0d", i),
          32'(alive_o), 32'((1 << (i + 1)) - 1));
    end
    step();
    shut_ack_i = 0;
    chk("sh_idle", 32'(state_o), 0);
    chk("sh_alive", 32'(alive_o), 0);
    chk("sh_flt", 32'(fault_o), 0);
    chk("sh_sreq", 32'(shut_req_o), 0);
    pulse_stop();
    chk("idle_stop_ign", 32'(state_o), 0);

    // Init error at idx 3 (err beats ack), stray err ignored.
    pulse_start();
    init_ack_i = 8'hFF;
    init_err_i = 8'h08;
    step(); step(); step();
    chk("er_req3", 32'(init_req_o), 32'h08);
    chk("er_alv", 32'(alive_o), 32'h07);
    step();
    init_ack_i = 0; init_err_i = 0;
    chk("er_st", 32'(state_o), 4);
    chk("er_sreq", 32'(shut_req_o), 32'h04);
    chk("er_ireq", 32'(init_req_o), 0);
    chk("er_flt", 32'(fault_o), 1);
    chk("er_fidx", 32'(fault_idx_o), 3);
    pulse_start();
    chk("uw_start_ign", 32'(state_o), 4);
    shut_ack_i = 8'hFF;
    step();
    chk("uw_req1", 32'(shut_req_o), 32'h02);
    step();
    chk("uw_req0", 32'(shut_req_o), 32'h01);
    step();
    shut_ack_i = 0;
    chk("uw_st", 32'(state_o), 5);
    chk("uw_alive", 32'(alive_o), 0);
    chk("uw_fidx", 32'(fault_idx_o), 3);
    chk("uw_ftmo", 32'(fault_tmo_o), 0);
    chk("uw_busy", 32'(busy_o), 0);
    pulse_stop();
    chk("flt_stop_ign", 32'(state_o), 5);

    // Stall at idx 5: timeout (or, without watchdog, eternal wait).
    pulse_start();
    chk("to_fclr", 32'(fault_o), 0);
    chk("to_fidxclr", 32'(fault_idx_o), 0);
    init_ack_i = 8'hFF;
    step(); step(); step(); step(); step();
    init_ack_i = 8'hDF;
    chk("to_req5", 32'(init_req_o), 32'h20);
`ifdef SUBSYS_SEQ_TIMEOUT_EN
    repeat (9) step();
    chk("to_hold", 32'(init_req_o), 32'h20);
    chk("to_noflt", 32'(fault_o), 0);
    step();
`else
    repeat (30) step();
    chk("to_hold", 32'(init_req_o), 32'h20);
    chk("to_noflt", 32'(fault_o), 0);
    init_err_i = 8'h20;
    step();
    init_err_i = 0;
`endif
    init_ack_i = 0;
    chk("to_st", 32'(state_o), 4);
    chk("to_sreq", 32'(shut_req_o), 32'h10);
    chk("to_flt", 32'(fault_o), 1);
    chk("to_fidx", 32'(fault_idx_o), 5);
    chk("to_ftmo", 32'(fault_tmo_o), 32'(TMO_EXP));
    shut_ack_i = 8'hFF;
    repeat (5) step();
    shut_ack_i = 0;
    chk("to_end", 32'(state_o), 5);
    chk("to_alive", 32'(alive_o), 0);

    // Stop while idx 2 is pending.
    pulse_start();
    init_ack_i = 8'hFF;
    step(); step();
    init_ack_i = 0;
    chk("ps_req2", 32'(init_req_o), 32'h04);
    pulse_stop();
    chk("ps_wait", 32'(init_req_o), 32'h04);
    chk("ps_wst", 32'(state_o), 1);
    step();
    init_ack_i = 8'h04;
    step();
    init_ack_i = 0;
    chk("ps_st", 32'(state_o), 3);
    chk("ps_sreq", 32'(shut_req_o), 32'h04);
    chk("ps_ireq", 32'(init_req_o), 0);
    chk("ps_alive", 32'(alive_o), 32'h07);
    shut_ack_i = 8'hFF;
    step(); step(); step();
    shut_ack_i = 0;
    chk("ps_idle", 32'(state_o), 0);
    chk("ps_flt", 32'(fault_o), 0);
    chk("ps_alive0", 32'(alive_o), 0);

    // Async reset during idx 4 handshake.
    pulse_start();
    init_ack_i = 8'hFF;
    repeat (4) step();
    init_ack_i = 0;
    chk("ar_req4", 32'(init_req_o), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_idle", 32'(state_o), 0);
    pulse_start();
    chk("ar_restart", 32'(init_req_o), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
